// File: rtl/pacessor_pkg.sv
// Shared definitions for the program loader: FSM encoding, default memory
// geometry and load-handshake widths.
package pacessor_pkg;

  localparam int MEM_BYTES_DEF = 64;
  localparam int HOLD_CYC_DEF  = 2;

  // Processor fetch address width and byte-count width seen on the ports.
  localparam int ADDR_W  = 6;
  localparam int COUNT_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/prog_loader_mem_if.sv
// Load-port and fetch-port bundle between a program source and the loader.
interface prog_loader_mem_if;
  import pacessor_pkg::*;

  logic               ld_start;
  logic               ld_valid;
  logic [7:0]         ld_data;
  logic               ld_last;
  logic               ld_ready;
  logic               ld_done;
  logic [COUNT_W-1:0] ld_count;
  logic [ADDR_W-1:0]  add_i;
  logic [31:0]        inst;
  logic               cpu_rst;

  // Program source / processor side.
  modport master (
    output ld_start, ld_valid, ld_data, ld_last, add_i,
    input  ld_ready, ld_done, ld_count, inst, cpu_rst
  );

  // Loader side.
  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, add_i,
    output ld_ready, ld_done, ld_count, inst, cpu_rst
  );

endinterface

// File: rtl/byte_ram.sv
// Byte-wide program memory: one synchronous write port and a combinational
// 4-byte big-endian read that wraps around the end of the array.
module byte_ram
  import pacessor_pkg::*;
#(
  parameter  int DEPTH   = MEM_BYTES_DEF,
  parameter  int RADDR_W = ADDR_W,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [7:0]         wdata,
  input  logic [RADDR_W-1:0] raddr,
  output logic [31:0]        rdata
);

  logic [7:0] mem [DEPTH];

  // Byte write; reset wipes the whole program image.
  // NOTE: clearing every byte on reset forces this array into flops rather
  // than a RAM macro; that is intended, the processor must never fetch stale
  // code after a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      // NOTE: non-blocking assignment keeps every register update in this
      // edge ordered against the readers of the old value.
      mem[waddr] <= wdata;
    end
  end

  // Instruction fetch: bytes a..a+3 modulo DEPTH, lowest address in the MSBs.
  always_comb begin
    // NOTE: default first so no path through the block leaves rdata unassigned
    // and a latch is never inferred.
    rdata = '0;
    for (int k = 0; k < 4; k++) begin
      rdata[31 - 8*k -: 8] = mem[AW'((int'(raddr) + k) % DEPTH)];
    end
  end

endmodule

// File: rtl/prog_loader_mem.sv
// Program loader: accepts a byte stream into program memory, holds the
// processor in reset while loading and for a few cycles afterwards, then
// releases it to fetch from the loaded image.
module prog_loader_mem
  import pacessor_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst_master,
  prog_loader_mem_if.slave       bus
);

  localparam int PTR_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(MEM_BYTES - 1);

  ld_state_e          state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [7:0]         hold_cnt;
  logic               ld_ready_q;
  logic               ld_done_q;
  logic [COUNT_W-1:0] ld_count_q;
  logic               cpu_rst_q;

  logic wr_en;
  logic load_end;

  // A byte is taken only in LOAD and only when no restart arrives with it.
  assign wr_en    = (state == LOAD) && bus.ld_valid && !bus.ld_start;
  // The load ends on ld_last or on the byte that fills the last address.
  assign load_end = wr_en && (bus.ld_last || (wr_ptr == LAST_ADDR));

  // Load sequencer: state, write pointer, byte count and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_master) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      hold_cnt   <= '0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      ld_count_q <= '0;
      cpu_rst_q  <= 1'b1;
    end else begin
      ld_done_q <= 1'b0;
      case (state)
        IDLE: begin
          cpu_rst_q <= 1'b1;
          if (bus.ld_start) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            ld_count_q <= '0;
            ld_ready_q <= 1'b1;
          end
        end

        LOAD: begin
          if (bus.ld_start) begin
            // Restart: a byte presented in the same cycle is discarded.
            wr_ptr     <= '0;
            ld_count_q <= '0;
          end else if (wr_en) begin
            ld_count_q <= ld_count_q + COUNT_W'(1);
            // The pointer parks on the last address instead of wrapping.
            if (wr_ptr != LAST_ADDR) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load_end) begin
              state      <= HOLD;
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
              hold_cnt   <= '0;
            end
          end
        end

        HOLD: begin
          // ld_start is deliberately ignored here.
          if (int'(hold_cnt) + 1 >= HOLD_CYC) begin
            state     <= RUN;
            cpu_rst_q <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        RUN: begin
          if (bus.ld_start) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            ld_count_q <= '0;
            ld_ready_q <= 1'b1;
            cpu_rst_q  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.ld_count = ld_count_q;
  assign bus.cpu_rst  = cpu_rst_q;

  byte_ram #(
    .DEPTH   (MEM_BYTES),
    .RADDR_W (ADDR_W)
  ) u_byte_ram (
    .clk   (clk),
    .rst   (rst_master),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.ld_data),
    .raddr (bus.add_i),
    .rdata (bus.inst)
  );

endmodule

// File: tb/tb_prog_loader_mem.sv
// Self-checking bench for prog_loader_mem: directed scenarios plus randomized
// loads, compared against a byte-array image of what the program should be.
module tb_prog_loader_mem;

  localparam int MEM = 64;
  localparam int HC  = 2;

  logic clk = 1'b0;
  logic rst_master;

  always #5 clk = ~clk;

  prog_loader_mem_if bus ();

  prog_loader_mem #(
    .MEM_BYTES (MEM),
    .HOLD_CYC  (HC)
  ) dut (
    .clk        (clk),
    .rst_master (rst_master),
    .bus        (bus)
  );

  int vectors;
  int miscompares;

  // Expected program image.
  logic [7:0] ref_mem [MEM];

  function automatic logic [31:0] ref_inst(input int a);
    return {ref_mem[a % MEM], ref_mem[(a + 1) % MEM],
            ref_mem[(a + 2) % MEM], ref_mem[(a + 3) % MEM]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = 8'h00;
    bus.ld_last  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_master = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst_master = 1'b0;
    for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic pulse_start();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  // Bounded wait for the processor to be released from reset.
  task automatic wait_run(input string name);
    for (int i = 0; i < 8 && bus.cpu_rst !== 1'b0; i++) tick();
    vectors++;
    if (bus.cpu_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_run_timeout cpu_rst=%b expected=0", name, bus.cpu_rst);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({bus.ld_ready, bus.ld_done, bus.cpu_rst} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_flags ready/done/cpu_rst=%b expected=001",
               {bus.ld_ready, bus.ld_done, bus.cpu_rst});
    end
    vectors++;
    if (bus.ld_count !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_count ld_count=%0d expected=0", bus.ld_count);
    end
    for (int a = 0; a < MEM; a += 8) begin
      bus.add_i = 6'(a);
      #1;
      vectors++;
      if (bus.inst !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_inst add_i=%0d inst=%h expected=00000000", a, bus.inst);
      end
    end
  endtask

  task automatic test_basic_load();
    logic [7:0] prog [4];
    prog = '{8'h10, 8'h00, 8'h05, 8'h00};
    bus.add_i = 6'd0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.ld_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL basic_ready byte=%0d ld_ready=%b expected=1", i, bus.ld_ready);
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = prog[i];
      bus.ld_last  = (i == 3);
      tick();
      ref_mem[i] = prog[i];
      idle_inputs();
      // The byte written on that edge is already visible on inst.
      vectors++;
      if (bus.inst !== ref_inst(0)) begin
        miscompares++;
        $display("FAIL basic_visible byte=%0d inst=%h expected=%h", i, bus.inst, ref_inst(0));
      end
      vectors++;
      if (bus.ld_done !== (i == 3)) begin
        miscompares++;
        $display("FAIL basic_done byte=%0d ld_done=%b expected=%b", i, bus.ld_done, i == 3);
      end
    end
    vectors++;
    if (bus.ld_count !== 7'd4 || bus.ld_ready !== 1'b0 || bus.cpu_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_hold1 count=%0d ready=%b cpu_rst=%b expected=4,0,1",
               bus.ld_count, bus.ld_ready, bus.cpu_rst);
    end
    // ld_start during HOLD must have no effect.
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    vectors++;
    if (bus.ld_done !== 1'b0 || bus.cpu_rst !== 1'b1 || bus.ld_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_hold2 done=%b cpu_rst=%b ready=%b expected=0,1,0",
               bus.ld_done, bus.cpu_rst, bus.ld_ready);
    end
    tick();
    vectors++;
    if (bus.cpu_rst !== 1'b0 || bus.ld_count !== 7'd4) begin
      miscompares++;
      $display("FAIL basic_run cpu_rst=%b count=%0d expected=0,4", bus.cpu_rst, bus.ld_count);
    end
    bus.add_i = 6'd0;
    #1;
    vectors++;
    if (bus.inst !== 32'h10000500) begin
      miscompares++;
      $display("FAIL basic_inst inst=%h expected=10000500", bus.inst);
    end
  endtask

  task automatic test_full_load();
    pulse_start();
    for (int i = 0; i < MEM; i++) begin
      vectors++;
      if (bus.ld_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL full_ready byte=%0d ld_ready=%b expected=1", i, bus.ld_ready);
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'($urandom);
      bus.ld_last  = 1'b0;
      ref_mem[i]   = bus.ld_data;
      tick();
      vectors++;
      if (bus.ld_count !== 7'(i + 1)) begin
        miscompares++;
        $display("FAIL full_count byte=%0d ld_count=%0d expected=%0d", i, bus.ld_count, i + 1);
      end
    end
    vectors++;
    if (bus.ld_ready !== 1'b0 || bus.ld_done !== 1'b1) begin
      miscompares++;
      $display("FAIL full_end ready=%b done=%b expected=0,1", bus.ld_ready, bus.ld_done);
    end
    // A byte offered after the load ended must not land anywhere.
    bus.ld_data = ~ref_mem[0];
    tick();
    idle_inputs();
    wait_run("full");
    for (int a = 0; a < MEM; a++) begin
      bus.add_i = 6'(a);
      #1;
      vectors++;
      if (bus.inst !== ref_inst(a)) begin
        miscompares++;
        $display("FAIL full_inst add_i=%0d inst=%h expected=%h", a, bus.inst, ref_inst(a));
      end
    end
    bus.add_i = 6'd62;
    #1;
    vectors++;
    if (bus.inst !== {ref_mem[62], ref_mem[63], ref_mem[0], ref_mem[1]}) begin
      miscompares++;
      $display("FAIL full_wrap62 inst=%h expected=%h", bus.inst,
               {ref_mem[62], ref_mem[63], ref_mem[0], ref_mem[1]});
    end
  endtask

  task automatic test_valid_toggle();
    int accepted;
    accepted = 0;
    pulse_start();
    for (int c = 0; accepted < 10; c++) begin
      bus.ld_valid = (c % 2 == 0);
      bus.ld_data  = 8'($urandom);
      bus.ld_last  = bus.ld_valid && (accepted == 9);
      if (bus.ld_valid) begin
        ref_mem[accepted] = bus.ld_data;
        accepted++;
      end
      tick();
      vectors++;
      if (bus.ld_count !== 7'(accepted)) begin
        miscompares++;
        $display("FAIL toggle_count cycle=%0d ld_count=%0d expected=%0d", c, bus.ld_count, accepted);
      end
    end
    idle_inputs();
    vectors++;
    if (bus.ld_done !== 1'b1) begin
      miscompares++;
      $display("FAIL toggle_done ld_done=%b expected=1", bus.ld_done);
    end
    wait_run("toggle");
    for (int a = 0; a < MEM; a++) begin
      bus.add_i = 6'(a);
      #1;
      vectors++;
      if (bus.inst !== ref_inst(a)) begin
        miscompares++;
        $display("FAIL toggle_inst add_i=%0d inst=%h expected=%h", a, bus.inst, ref_inst(a));
      end
    end
  endtask

  task automatic test_restart();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'($urandom);
      ref_mem[i]   = bus.ld_data;
      tick();
    end
    // Restart with a byte in the same cycle: the byte is dropped.
    bus.ld_start = 1'b1;
    bus.ld_data  = 8'($urandom);
    tick();
    bus.ld_start = 1'b0;
    vectors++;
    if (bus.ld_count !== 7'd0 || bus.ld_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_clear count=%0d ready=%b expected=0,1", bus.ld_count, bus.ld_ready);
    end
    bus.ld_data = 8'($urandom);
    bus.ld_last = 1'b1;
    ref_mem[0]  = bus.ld_data;
    tick();
    idle_inputs();
    vectors++;
    if (bus.ld_count !== 7'd1 || bus.ld_done !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_end count=%0d done=%b expected=1,1", bus.ld_count, bus.ld_done);
    end
    for (int a = 0; a < 4; a++) begin
      bus.add_i = 6'(a);
      #1;
      vectors++;
      if (bus.inst !== ref_inst(a)) begin
        miscompares++;
        $display("FAIL restart_inst add_i=%0d inst=%h expected=%h", a, bus.inst, ref_inst(a));
      end
    end
    wait_run("restart");
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'($urandom);
      tick();
    end
    idle_inputs();
    rst_master = 1'b1;
    tick();
    rst_master = 1'b0;
    for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({bus.ld_ready, bus.ld_done, bus.cpu_rst} !== 3'b001 || bus.ld_count !== 7'd0) begin
        miscompares++;
        $display("FAIL midrst_flags cycle=%0d ready/done/cpu_rst=%b count=%0d expected=001,0",
                 c, {bus.ld_ready, bus.ld_done, bus.cpu_rst}, bus.ld_count);
      end
      tick();
    end
    for (int a = 0; a < MEM; a++) begin
      bus.add_i = 6'(a);
      #1;
      vectors++;
      if (bus.inst !== 32'h0) begin
        miscompares++;
        $display("FAIL midrst_inst add_i=%0d inst=%h expected=00000000", a, bus.inst);
      end
    end
  endtask

  task automatic test_random_loads();
    for (int n = 0; n < 6; n++) begin
      int len;
      int accepted;
      bit use_last;
      len      = (n == 0) ? MEM : $urandom_range(1, MEM);
      use_last = (len < MEM) ? 1'b1 : 1'($urandom_range(0, 1));
      accepted = 0;
      pulse_start();
      for (int c = 0; accepted < len && c < 400; c++) begin
        vectors++;
        if (bus.ld_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL rand_ready load=%0d cycle=%0d ld_ready=%b expected=1", n, c, bus.ld_ready);
        end
        bus.ld_valid = ($urandom_range(0, 2) != 0);
        bus.ld_data  = 8'($urandom);
        bus.ld_last  = bus.ld_valid && use_last && (accepted == len - 1);
        if (bus.ld_valid) begin
          ref_mem[accepted] = bus.ld_data;
          accepted++;
        end
        tick();
        vectors++;
        if (bus.ld_count !== 7'(accepted)) begin
          miscompares++;
          $display("FAIL rand_count load=%0d ld_count=%0d expected=%0d", n, bus.ld_count, accepted);
        end
      end
      idle_inputs();
      vectors++;
      if (bus.ld_done !== 1'b1 || bus.ld_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_end load=%0d len=%0d done=%b ready=%b expected=1,0",
                 n, len, bus.ld_done, bus.ld_ready);
      end
      wait_run("rand");
      for (int a = 0; a < MEM; a++) begin
        bus.add_i = 6'(a);
        #1;
        vectors++;
        if (bus.inst !== ref_inst(a)) begin
          miscompares++;
          $display("FAIL rand_inst load=%0d add_i=%0d inst=%h expected=%h",
                   n, a, bus.inst, ref_inst(a));
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.add_i   = 6'd0;
    idle_inputs();
    test_reset();
    test_basic_load();
    test_full_load();
    test_valid_toggle();
    test_restart();
    test_reset_mid_load();
    test_random_loads();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
